// File: rtl/fepow_if.sv
// fepow_if: request/result handshake and external field-multiplier channel
// for the fepow modular exponentiator. The exponentiator connects through the
// slave modport; the requester and multiplier side uses the master modport.
interface fepow_if;
  logic         start;
  logic [254:0] a_in;
  logic         busy;
  logic         done;
  logic [254:0] out;
  logic         mul_start;
  logic [254:0] mul_a;
  logic [254:0] mul_b;
  logic         mul_done;
  logic [254:0] mul_out;

  modport slave (
    input  start, a_in, mul_done, mul_out,
    output busy, done, out, mul_start, mul_a, mul_b
  );

  modport master (
    output start, a_in, mul_done, mul_out,
    input  busy, done, out, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/fepow.sv
// fepow: fixed-exponent modular exponentiation a^E mod p (p = 2^255-19) by
// left-to-right square-and-multiply. Each multiplication is delegated to an
// external field multiplier, and only one operation is in flight at a time.
// The default exponent p-2 makes the block a field inverter.
//
// Optional feature: define FEPOW_ZERO_BYPASS_EN to complete a zero operand in
// one cycle with no multiplications. When it is undefined, zero runs the full
// schedule and no zero comparator exists.
module fepow #(
  parameter logic [254:0] E   = ~255'd20,  // 2^255-21 = p-2
  parameter int           TOP = 254        // index of the most significant set bit of E
) (
  input  logic   clock,
  input  logic   reset_n,
  fepow_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic {
    SQ  = 1'b0,
    MUL = 1'b1
  } phase_t;

  // The exponent scan starts just below the leading one, because r = a already
  // accounts for that bit.
  localparam logic [7:0] IDX_FIRST   = (TOP > 0) ? 8'(TOP - 1) : 8'd0;
  localparam logic       TOP_IS_ZERO = (TOP == 0) ? 1'b1 : 1'b0;

  state_t       state_r;
  phase_t       phase_r;
  logic [7:0]   idx_r;
  logic [254:0] base_r;
  logic         busy_r;
  logic         done_r;
  logic         mul_start_r;
  logic [254:0] out_r;
  logic [254:0] mul_a_r;
  logic [254:0] mul_b_r;
  logic         zero_s;
  logic         e_bit_s;

  // Detect a zero operand that can skip the multiplier entirely.
  always_comb begin
`ifdef FEPOW_ZERO_BYPASS_EN
    zero_s = (bus.a_in == 255'd0) ? 1'b1 : 1'b0;
`else
    zero_s = 1'b0;
`endif
  end

  assign e_bit_s = E[idx_r];

  // Sequencer: accept a request, issue and collect products, publish the result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      phase_r     <= SQ;
      idx_r       <= 8'd0;
      base_r      <= 255'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mul_start_r <= 1'b0;
      out_r       <= 255'd0;
      mul_a_r     <= 255'd0;
      mul_b_r     <= 255'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r      <= 1'b0;
          mul_start_r <= 1'b0;
          if (bus.start) begin
            busy_r  <= 1'b1;
            base_r  <= bus.a_in;
            idx_r   <= IDX_FIRST;
            phase_r <= SQ;
            mul_a_r <= bus.a_in;
            mul_b_r <= bus.a_in;
            if (TOP_IS_ZERO || zero_s) begin
              // a^1 = a, and 0^E = 0: the operand itself is the result.
              out_r   <= bus.a_in;
              done_r  <= 1'b1;
              state_r <= FINISH;
            end else begin
              mul_start_r <= 1'b1;
              state_r     <= ISSUE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        ISSUE: begin
          mul_start_r <= 1'b0;
          state_r     <= WAIT;
        end

        WAIT: begin
          if (bus.mul_done) begin
            if ((phase_r == SQ) && e_bit_s) begin
              // Square done and this exponent bit is set: multiply by the base.
              phase_r     <= MUL;
              mul_a_r     <= bus.mul_out;
              mul_b_r     <= base_r;
              mul_start_r <= 1'b1;
              state_r     <= ISSUE;
            end else if (idx_r != 8'd0) begin
              idx_r       <= idx_r - 8'd1;
              phase_r     <= SQ;
              mul_a_r     <= bus.mul_out;
              mul_b_r     <= bus.mul_out;
              mul_start_r <= 1'b1;
              state_r     <= ISSUE;
            end else begin
              out_r   <= bus.mul_out;
              done_r  <= 1'b1;
              state_r <= FINISH;
            end
          end else begin
            state_r <= WAIT;
          end
        end

        FINISH: begin
          // A start in this cycle is ignored; IDLE accepts from the next cycle.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          mul_start_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.out       = out_r;
  assign bus.mul_start = mul_start_r;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;

endmodule

// File: tb/tb_fepow.sv
// tb_fepow: self-checking bench for fepow. It uses behavioural field
// multipliers with configurable latency and a reference exponentiation written
// independently with right-to-left binary powering.
module tb_fepow;

  localparam logic [254:0] P  = ~255'd18;          // 2^255-19
  localparam logic [254:0] E1 = ~255'd20;          // p-2
  localparam logic [254:0] E2 = {3'd0, ~252'd1};   // (p+3)/8 = 2^252-2

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   lat      = 1;
  bit   mon_en   = 1'b1;
  int   viol     = 0;
  int   last_ms  = -1;

  fepow_if bus ();
  fepow_if bus2 ();

  fepow dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  fepow #(.E(E2), .TOP(251)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  always #5 clock = ~clock;

  // Cycle counter: a value read at a negedge is the index of the current cycle.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] prod;
    prod = {255'd0, x} * {255'd0, y};
    return 255'(prod % {255'd0, P});
  endfunction

  function automatic logic [254:0] modpow(input logic [254:0] a, input logic [254:0] e);
    logic [254:0] r;
    logic [254:0] b;
    r = 255'd1;
    b = mulmod(a, 255'd1);
    for (int i = 0; i < 255; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic logic [254:0] rand_fe();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[254:0];
  endfunction

  // Behavioural multiplier for dut: the product appears lat cycles after mul_start.
  logic [254:0] pa, pb;
  int mrem = 0;
  always @(posedge clock) begin
    bus.mul_done <= 1'b0;
    if (bus.mul_start) begin
      pa <= bus.mul_a;
      pb <= bus.mul_b;
      if (lat == 1) begin
        bus.mul_done <= 1'b1;
        bus.mul_out  <= mulmod(bus.mul_a, bus.mul_b);
        mrem         <= 0;
      end else begin
        mrem <= lat - 1;
      end
    end else if (mrem != 0) begin
      mrem <= mrem - 1;
      if (mrem == 1) begin
        bus.mul_done <= 1'b1;
        bus.mul_out  <= mulmod(pa, pb);
      end
    end
  end

  // Behavioural multiplier for dut2.
  logic [254:0] pa2, pb2;
  int mrem2 = 0;
  always @(posedge clock) begin
    bus2.mul_done <= 1'b0;
    if (bus2.mul_start) begin
      pa2 <= bus2.mul_a;
      pb2 <= bus2.mul_b;
      if (lat == 1) begin
        bus2.mul_done <= 1'b1;
        bus2.mul_out  <= mulmod(bus2.mul_a, bus2.mul_b);
        mrem2         <= 0;
      end else begin
        mrem2 <= lat - 1;
      end
    end else if (mrem2 != 0) begin
      mrem2 <= mrem2 - 1;
      if (mrem2 == 1) begin
        bus2.mul_done <= 1'b1;
        bus2.mul_out  <= mulmod(pa2, pb2);
      end
    end
  end

  // Protocol monitor: single outstanding op, stable operands, issue spacing of lat+1.
  always @(negedge clock) begin
    if (!reset_n || !bus.busy) begin
      last_ms <= -1;
    end else if (mon_en) begin
      if (bus.mul_start) begin
        if (mrem != 0) viol <= viol + 1;
        if (last_ms >= 0 && (cyc - last_ms) != lat + 1) viol <= viol + 1;
        last_ms <= cyc;
      end else if (mrem != 0 && (bus.mul_a !== pa || bus.mul_b !== pb)) begin
        viol <= viol + 1;
      end
    end
  end

  // Drive one request on dut and observe it until a few cycles after done.
  task automatic run_op(input logic [254:0] a, input int lat_i, input int exp_done, input bit poke,
                        output logic [254:0] res, output int dcyc, output int ns,
                        output bit b1, output bit bd, output bit ba, output int ndone);
    lat = lat_i;
    ns = 0; dcyc = -1; res = 255'd0; b1 = 1'b0; bd = 1'b0; ba = 1'b1; ndone = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.a_in  = a;
    for (int k = 1; k <= exp_done + 64; k++) begin
      @(negedge clock);
      if (k == 1) b1 = bus.busy;
      if (bus.mul_start) ns++;
      if (dcyc > 0 && k == dcyc + 1) ba = bus.busy;
      if (bus.done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = k;
          res  = bus.out;
          bd   = bus.busy;
        end
      end
      if (poke && (k == 7 || k == exp_done)) begin
        bus.start = 1'b1;
        bus.a_in  = 255'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (dcyc > 0 && k >= dcyc + 3) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.a_in = 255'd9; bus2.start = 1'b0; bus2.a_in = 255'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mul_start !== 1'b0)
      $display("FAIL reset_ctrl: busy=%b done=%b mul_start=%b, required 0 0 0", bus.busy, bus.done, bus.mul_start);
    n_checks++;
    if (bus.out !== 255'd0 || bus.mul_a !== 255'd0 || bus.mul_b !== 255'd0) begin
      n_fail++;
      $display("FAIL reset_data: out=%h mul_a=%h mul_b=%h, required 0", bus.out, bus.mul_a, bus.mul_b);
    end
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mul_start !== 1'b0) n_fail++;
    // Request on the very first edge after release.
    lat = 1;
    bus.a_in = 255'd1;
    reset_n  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mul_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_start: busy=%b mul_start=%b, required 1 1", bus.busy, bus.mul_start);
    end
    for (int k = 0; k < 1100 && bus.done !== 1'b1; k++) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.out !== 255'd1) begin
      n_fail++;
      $display("FAIL first_edge_result: done=%b out=%h, required done 1 out 1", bus.done, bus.out);
    end
    @(negedge clock);
  endtask

  task automatic test_one_long_latency();
    logic [254:0] res; int dc, ns, nd; bit b1, bd, ba; int v0;
    v0 = viol;
    run_op(255'd1, 32, 16699, 1'b0, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== 255'd1) begin n_fail++; $display("FAIL one_result: got %h, required 1", res); end
    n_checks++;
    if (dc != 16699) begin n_fail++; $display("FAIL one_done_cycle: got %0d, required 16699", dc); end
    n_checks++;
    if (ns != 506) begin n_fail++; $display("FAIL one_mul_count: got %0d, required 506", ns); end
    n_checks++;
    if (!b1 || !bd || ba || nd != 1) begin
      n_fail++;
      $display("FAIL one_busy: busy@1=%b busy@done=%b busy@after=%b dones=%0d, required 1 1 0 1", b1, bd, ba, nd);
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL one_protocol: %0d violations, required 0", viol - v0); end
  endtask

  task automatic test_inverse();
    logic [254:0] res; int dc, ns, nd, l; bit b1, bd, ba;
    l = int'($urandom_range(3, 1));
    run_op(255'd2, l, 1 + 506 * (l + 1), 1'b0, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== {1'b0, ~254'd8}) begin n_fail++; $display("FAIL inv2: got %h, required %h", res, {1'b0, ~254'd8}); end
    n_checks++;
    if (mulmod(res, 255'd2) !== 255'd1) begin n_fail++; $display("FAIL inv2_product: got %h, required 1", mulmod(res, 255'd2)); end
    n_checks++;
    if (dc != 1 + 506 * (l + 1)) begin n_fail++; $display("FAIL inv2_done_cycle: got %0d, required %0d", dc, 1 + 506 * (l + 1)); end
    run_op(P - 255'd1, l, 1 + 506 * (l + 1), 1'b0, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== P - 255'd1) begin n_fail++; $display("FAIL inv_pm1: got %h, required %h", res, P - 255'd1); end
  endtask

  task automatic test_zero();
    logic [254:0] res; int dc, ns, nd; bit b1, bd, ba;
`ifdef FEPOW_ZERO_BYPASS_EN
    run_op(255'd0, 32, 1, 1'b0, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== 255'd0 || dc != 1 || ns != 0) begin
      n_fail++;
      $display("FAIL zero_bypass: out=%h done_cycle=%0d muls=%0d, required 0 1 0", res, dc, ns);
    end
    n_checks++;
    if (!b1 || ba) begin n_fail++; $display("FAIL zero_busy: busy@1=%b busy@2=%b, required 1 0", b1, ba); end
`else
    run_op(255'd0, 32, 16699, 1'b0, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== 255'd0 || dc != 16699 || ns != 506) begin
      n_fail++;
      $display("FAIL zero_full: out=%h done_cycle=%0d muls=%0d, required 0 16699 506", res, dc, ns);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    logic [254:0] res; int dc, ns, nd; bit b1, bd, ba; int v0;
    v0 = viol;
    run_op(255'd5, 2, 1 + 506 * 3, 1'b1, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== modpow(255'd5, E1)) begin n_fail++; $display("FAIL busy_ignore_result: got %h, required %h", res, modpow(255'd5, E1)); end
    n_checks++;
    if (nd != 1 || ba || dc != 1 + 506 * 3) begin
      n_fail++;
      $display("FAIL busy_ignore_done: dones=%0d busy@after=%b cycle=%0d, required 1 0 %0d", nd, ba, dc, 1 + 506 * 3);
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL busy_ignore_protocol: %0d violations, required 0", viol - v0); end
  endtask

  task automatic test_random();
    logic [254:0] a, res, exp_r; int dc, ns, nd, l; bit b1, bd, ba; int v0;
    v0 = viol;
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? P + 255'd5 : rand_fe();
      l = int'($urandom_range(3, 1));
      exp_r = modpow(a, E1);
      run_op(a, l, 1 + 506 * (l + 1), 1'b0, res, dc, ns, b1, bd, ba, nd);
      n_checks++;
      if (res !== exp_r || dc != 1 + 506 * (l + 1)) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h out=%h cycle=%0d, required out %h cycle %0d", t, a, res, dc, exp_r, 1 + 506 * (l + 1));
      end
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL random_protocol: %0d violations, required 0", viol - v0); end
  endtask

  task automatic test_reset_abort();
    logic [254:0] res; int dc, ns, nd, nstart; bit b1, bd, ba, spurious;
    lat = 8;
    @(negedge clock);
    bus.start = 1'b1; bus.a_in = 255'd9;
    @(negedge clock);
    bus.start = 1'b0;
    nstart = bus.mul_start ? 1 : 0;
    for (int k = 0; k < 2000 && nstart < 100; k++) begin
      @(negedge clock);
      if (bus.mul_start) nstart++;
    end
    repeat (3) @(negedge clock);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mul_start !== 1'b0 || bus.out !== 255'd0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b mul_start=%b out=%h, required 0 0 0", bus.busy, bus.mul_start, bus.out);
    end
    @(negedge clock);
    reset_n  = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (bus.done || bus.busy || bus.mul_start) spurious = 1'b1;
    end
    mon_en = 1'b1;
    n_checks++;
    if (spurious) begin n_fail++; $display("FAIL abort_stale: activity after stale mul_done, required none"); end
    run_op(255'd3, 8, 1 + 506 * 9, 1'b0, res, dc, ns, b1, bd, ba, nd);
    n_checks++;
    if (res !== modpow(255'd3, E1) || dc != 1 + 506 * 9 || nd != 1) begin
      n_fail++;
      $display("FAIL abort_restart: out=%h cycle=%0d dones=%0d, required %h %0d 1", res, dc, nd, modpow(255'd3, E1), 1 + 506 * 9);
    end
  endtask

  task automatic test_sqrt_exponent();
    logic [254:0] r2, sq; int dc, ns2, expd;
    dc = -1; ns2 = 0; r2 = 255'd0;
    lat  = int'($urandom_range(3, 1));
    expd = 1 + 501 * (lat + 1);
    @(negedge clock);
    bus2.start = 1'b1; bus2.a_in = 255'd4;
    for (int k = 1; k <= expd + 32 && dc < 0; k++) begin
      @(negedge clock);
      bus2.start = 1'b0;
      if (bus2.mul_start) ns2++;
      if (bus2.done) begin dc = k; r2 = bus2.out; end
    end
    n_checks++;
    if (r2 !== modpow(255'd4, E2)) begin n_fail++; $display("FAIL sqrt_result: got %h, required %h", r2, modpow(255'd4, E2)); end
    n_checks++;
    if (dc != expd || ns2 != 501) begin n_fail++; $display("FAIL sqrt_timing: cycle=%0d muls=%0d, required %0d 501", dc, ns2, expd); end
    // p = 5 mod 8, so this exponent gives a root candidate whose square is +-4.
    sq = mulmod(r2, r2);
    n_checks++;
    if (sq !== 255'd4 && sq !== P - 255'd4) begin n_fail++; $display("FAIL sqrt_square: got %h, required 4 or p-4", sq); end
  endtask

  initial begin
    test_reset();
    test_one_long_latency();
    test_inverse();
    test_zero();
    test_busy_ignore();
    test_random();
    test_reset_abort();
    test_sqrt_exponent();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
